// File: rtl/word_rebuilder.sv
// ---------------------------------------------------------------------------
// word_rebuilder
//   Rebuilds 32-bit words from byte-match tokens. Each token carries a match
//   mask, a dictionary index and packed literal bytes. The module keeps a
//   FIFO-replacement dictionary that follows the compressor's update policy.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            start of a new block: clears dictionary and error flag
//   i_valid / o_ready  token handshake (upstream)
//   i_match_mask       bit k set: byte k comes from the dictionary entry
//   i_dict_idx         referenced dictionary entry
//   i_literal          unmatched bytes packed from bit 0 upward
//   o_lit_bytes        combinational count of literal bytes in the token
//   o_valid / i_ready  rebuilt-word handshake (downstream)
//   o_word             rebuilt word (registered)
//   o_err              sticky: a token referenced an unwritten entry
// ---------------------------------------------------------------------------
module word_rebuilder #(
    parameter int unsigned DICT_DEPTH = 16,
    parameter int unsigned IDX_W      = $clog2(DICT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_match_mask,
    input  logic [IDX_W-1:0] i_dict_idx,
    input  logic [31:0]      i_literal,
    output logic [2:0]       o_lit_bytes,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_word,
    output logic             o_err
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTES_N = 4;

    // Dictionary storage
    logic [WORD_W-1:0]     dict_q [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] ent_vld_q;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;

    // Output and status registers
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    // Combinational helpers
    logic                  accept_c;
    logic                  dict_we_c;
    logic [WORD_W-1:0]     entry_c;
    logic [WORD_W-1:0]     rebuilt_c;
    logic [1:0]            cursor_c;
    logic [2:0]            lit_cnt_c;
    logic                  full_hit_c;
    logic                  miss_ref_c;

    // Handshake: stall on flush or when the output register cannot drain
    assign o_ready  = !i_flush && (!valid_q || i_ready);
    assign accept_c = i_valid && o_ready;

    // Literal byte count for the upstream bit unpacker
    always_comb begin
        lit_cnt_c = 3'd0;
        for (int k = 0; k < BYTES_N; k++) begin
            lit_cnt_c = lit_cnt_c + {2'b00, ~i_match_mask[k]};
        end
    end
    assign o_lit_bytes = lit_cnt_c;

    // Word rebuild: matched bytes from the entry, the rest consumed in order
    // from the packed literal. The cursor wraps after the fourth literal byte,
    // which is harmless because nothing reads it afterwards.
    always_comb begin
        entry_c   = dict_q[i_dict_idx];
        rebuilt_c = '0;
        cursor_c  = 2'd0;
        for (int k = 0; k < BYTES_N; k++) begin
            if (i_match_mask[k]) begin
                rebuilt_c[8*k +: 8] = entry_c[8*k +: 8];
            end else begin
                rebuilt_c[8*k +: 8] = i_literal[{cursor_c, 3'b000} +: 8];
                cursor_c            = cursor_c + 2'd1;
            end
        end
    end

    assign full_hit_c = (i_match_mask == 4'b1111);
    assign miss_ref_c = (i_match_mask != 4'b0000) && !ent_vld_q[i_dict_idx];
    assign dict_we_c  = accept_c && !full_hit_c;

    // Next-state logic for pointer, output register and error flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        word_d   = word_q;
        valid_d  = valid_q;
        err_d    = err_q;

        if (accept_c) begin
            word_d  = rebuilt_c;
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end

        if (i_flush) begin
            wr_ptr_d = '0;
            err_d    = 1'b0;
        end else if (accept_c) begin
            if (!full_hit_c) begin
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
            if (miss_ref_c) begin
                err_d = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Dictionary entries and valid bits; the oldest entry is overwritten
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent_vld_q <= '0;
            for (int e = 0; e < DICT_DEPTH; e++) begin
                dict_q[e] <= '0;
            end
        end else if (i_flush) begin
            ent_vld_q <= '0;
            for (int e = 0; e < DICT_DEPTH; e++) begin
                dict_q[e] <= '0;
            end
        end else if (dict_we_c) begin
            dict_q[wr_ptr_q]    <= rebuilt_c;
            ent_vld_q[wr_ptr_q] <= 1'b1;
        end
    end

    assign o_word  = word_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_word_rebuilder.sv
// ---------------------------------------------------------------------------
// tb_word_rebuilder
//   Directed bench for word_rebuilder with hand-computed expected words.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   after a further settle delay, away from the active edge.
// ---------------------------------------------------------------------------
module tb_word_rebuilder;

    localparam int unsigned DICT_DEPTH = 16;
    localparam int unsigned IDX_W      = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       match_mask;
    logic [IDX_W-1:0] dict_idx;
    logic [31:0]      literal;
    logic [2:0]       lit_bytes;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      word;
    logic             err;

    int n_checks;
    int n_fail;

    word_rebuilder #(
        .DICT_DEPTH (DICT_DEPTH),
        .IDX_W      (IDX_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_valid      (in_valid),
        .o_ready      (in_ready),
        .i_match_mask (match_mask),
        .i_dict_idx   (dict_idx),
        .i_literal    (literal),
        .o_lit_bytes  (lit_bytes),
        .o_valid      (out_valid),
        .i_ready      (out_ready),
        .o_word       (word),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one token, check the combinational side, accept it, check output
    task automatic send_tok(input string tag, input logic [3:0] m, input logic [IDX_W-1:0] idx,
                            input logic [31:0] lit, input logic [2:0] exp_lb,
                            input logic [31:0] exp_word);
        in_valid   = 1'b1;
        match_mask = m;
        dict_idx   = idx;
        literal    = lit;
        #1;
        check_eq({tag, "_litbytes"}, 32'(lit_bytes), 32'(exp_lb));
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_word"}, word, exp_word);
    endtask

    task automatic do_flush(input string tag);
        flush = 1'b1;
        #1;
        check_eq({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        match_mask = 4'b0000;
        dict_idx   = '0;
        literal    = '0;

        // Reset state
        repeat (2) tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_word", word, 32'h0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        tick();

        // Basic rebuild: literal, full hit, mixed
        send_tok("lit0", 4'b0000, 4'd0, 32'h1122_3344, 3'd4, 32'h1122_3344);
        send_tok("hit0", 4'b1111, 4'd0, 32'hDEAD_BEEF, 3'd0, 32'h1122_3344);
        send_tok("mix0", 4'b0101, 4'd0, 32'h0000_BBAA, 3'd2, 32'hBB22_AA44);
        // Full hit left wr_ptr at 1, so the mixed word landed in entry 1
        send_tok("hit1", 4'b1111, 4'd1, 32'h0, 3'd0, 32'hBB22_AA44);
        send_tok("hit0b", 4'b1111, 4'd0, 32'h0, 3'd0, 32'h1122_3344);
        send_tok("mix1", 4'b1000, 4'd1, 32'h0033_2211, 3'd3, 32'hBB33_2211);
        check_eq("err_clean", 32'(err), 32'd0);

        // Wrap: 17 literal words after a flush
        do_flush("fl_wrap");
        for (int n = 1; n <= 17; n++) begin
            send_tok("wrap_lit", 4'b0000, 4'd0, 32'h1000_0000 + 32'(n), 3'd4,
                     32'h1000_0000 + 32'(n));
        end
        send_tok("wrap_e0", 4'b1111, 4'd0, 32'h0, 3'd0, 32'h1000_0011);
        send_tok("wrap_e1", 4'b1111, 4'd1, 32'h0, 3'd0, 32'h1000_0002);
        send_tok("wrap_e15", 4'b1111, 4'd15, 32'h0, 3'd0, 32'h1000_0010);
        check_eq("wrap_err", 32'(err), 32'd0);

        // Error: reference to an unwritten entry after flush
        do_flush("fl_err");
        check_eq("err_pre", 32'(err), 32'd0);
        send_tok("err_tok", 4'b0011, 4'd5, 32'h0000_CCDD, 3'd2, 32'hCCDD_0000);
        check_eq("err_set", 32'(err), 32'd1);
        // The offending word was still written to entry 0
        send_tok("err_e0", 4'b1111, 4'd0, 32'h0, 3'd0, 32'hCCDD_0000);
        check_eq("err_hold", 32'(err), 32'd1);

        // Flush with a token pending: nothing accepted, error cleared
        in_valid   = 1'b1;
        match_mask = 4'b0000;
        literal    = 32'h7777_7777;
        do_flush("fl_pend");
        in_valid = 1'b0;
        check_eq("fl_drain", 32'(out_valid), 32'd0);
        check_eq("fl_err_clr", 32'(err), 32'd0);
        send_tok("fl_e0", 4'b1111, 4'd0, 32'h0, 3'd0, 32'h0000_0000);
        check_eq("fl_err_again", 32'(err), 32'd1);

        // Backpressure
        do_flush("fl_bp");
        send_tok("bp_a", 4'b0000, 4'd0, 32'hA5A5_0001, 3'd4, 32'hA5A5_0001);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        match_mask = 4'b0000;
        literal    = 32'hB0B0_0002;
        #1;
        check_eq("bp_ready0", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("bp_hold_word", word, 32'hA5A5_0001);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_b_word", word, 32'hB0B0_0002);
        check_eq("bp_b_valid", 32'(out_valid), 32'd1);
        tick();
        check_eq("bp_idle", 32'(out_valid), 32'd0);
        // B must have been written exactly once: next literal lands in entry 2
        send_tok("bp_c", 4'b0000, 4'd0, 32'hC0C0_0003, 3'd4, 32'hC0C0_0003);
        send_tok("bp_e2", 4'b1111, 4'd2, 32'h0, 3'd0, 32'hC0C0_0003);
        send_tok("bp_e1", 4'b1111, 4'd1, 32'h0, 3'd0, 32'hB0B0_0002);

        // Asynchronous reset mid-stream drops the in-flight word
        send_tok("ar_tok", 4'b0000, 4'd0, 32'h5555_AAAA, 3'd4, 32'h5555_AAAA);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 32'(out_valid), 32'd0);
        check_eq("ar_word", word, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        send_tok("ar_e0", 4'b1111, 4'd0, 32'h0, 3'd0, 32'h0000_0000);
        check_eq("ar_err", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
